// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver, 16x oversampling, feeding a first-word-fall-through FIFO.
// Latency: 2-clock input sync; byte written at stop-bit centre, visible on valid_o next cycle.
// Backpressure: valid/ready on the FIFO head; a byte arriving while full is dropped and flagged.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIV_W-1:0]              divisor_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rxs;

  logic [DIV_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic [3:0]       r_osc;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  logic             w_osc_clr;
  logic             w_shift_en;
  logic             w_push;
  logic             w_ferr;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             r_ferr;
  logic             r_ovr;

  assign w_rxs = r_sync2;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  // Oversample tick: held at 0 while idle so the phase lines up with start detection.
  assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == divisor_i);

  // Tick counter, wraps after reaching the divisor.
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state == S_IDLE) || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_osc_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_osc_clr   = 1'b1;
        end
      end
      S_START: begin
        // 8th tick lands in the middle of the start bit.
        if (w_tick && (r_osc == 4'd7)) begin
          w_osc_clr   = 1'b1;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && (r_osc == 4'd15)) begin
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tick && (r_osc == 4'd15)) begin
          if (w_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Stay here until the line recovers so a held-low line flags only once.
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Oversample and bit counters plus the LSB-first shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_osc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_osc_clr || (r_state == S_IDLE)) begin
        r_osc <= '0;
      end else if (w_tick) begin
        r_osc <= r_osc + 4'd1;
      end
      if (r_state == S_IDLE) begin
        r_bit <= '0;
      end else if (w_shift_en) begin
        r_bit <= r_bit + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_rxs, r_shift[7:1]};
      end
    end
  end

  // FIFO status; pointers carry one extra bit to tell full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_pop   = !w_empty && ready_i;
  assign w_wr    = w_push && (!w_full || w_pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= r_shift;
    end
  end

  // Pointers and the one-cycle error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      r_ferr <= w_ferr;
      r_ovr  <= w_push && w_full && !w_pop;
    end
  end

  assign valid_o     = !w_empty;
  assign count_o     = r_wptr - r_rptr;
  // Head is forced to 0 while empty so the output is clean out of reset.
  assign data_o      = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, bytes collected at the FIFO head.
// Expected bytes come from what was sent; pulses are counted at the falling clock edge.
// Inputs change 1 ns after the rising edge; checks are taken at that same point.
module tb_uart_rx_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] divisor_i = 16'd4;
  logic        rx_i = 1'b1;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [3:0]  count_o;
  logic        frame_err_o;
  logic        overrun_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  bit rnd_on = 1'b0;

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  uart_rx_fifo #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .divisor_i   (divisor_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .count_o     (count_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Collect popped bytes and count error pulses.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (frame_err_o) n_ferr++;
      if (overrun_o)   n_ovr++;
      if (valid_o && ready_i) got_q.push_back(data_o);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input int idx, input logic [7:0] exp);
    if (idx < got_q.size()) check(name, {24'h0, got_q[idx]}, {24'h0, exp});
    else check(name, 32'hFFFF_FFFF, {24'h0, exp});
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drive one 8N1 frame; with stop=0 the line stays low for extra_low more bit-times.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int div, input int extra_low);
    int bc;
    bc = 16 * (div + 1);
    rx_i = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clks(bc);
    end
    rx_i = stop;
    wait_clks(bc * (1 + extra_low));
    rx_i = 1'b1;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    wait_clks(12);
    ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    int base_f;
    int base_o;
    int nb;
    int div_r;

    vecs[0] = '{dat: 8'h65, stop: 1'b1, exp_push: 1, exp_ferr: 0};
    vecs[1] = '{dat: 8'h00, stop: 1'b1, exp_push: 1, exp_ferr: 0};
    vecs[2] = '{dat: 8'hFF, stop: 1'b1, exp_push: 1, exp_ferr: 0};
    vecs[3] = '{dat: 8'hA5, stop: 1'b0, exp_push: 0, exp_ferr: 1};
    vecs[4] = '{dat: 8'h80, stop: 1'b1, exp_push: 1, exp_ferr: 0};
    vecs[5] = '{dat: 8'h3C, stop: 1'b0, exp_push: 0, exp_ferr: 1};

    // Reset values
    wait_clks(5);
    check("rst_valid", {31'h0, valid_o}, 0);
    check("rst_count", {28'h0, count_o}, 0);
    check("rst_data", {24'h0, data_o}, 0);
    check("rst_ferr", {31'h0, frame_err_o}, 0);
    check("rst_ovr", {31'h0, overrun_o}, 0);
    rst_i = 1'b0;
    wait_clks(5);

    // Single frame latency and fall-through data
    divisor_i = 16'd4;
    got_q.delete();
    lat = 0;
    seen = 1'b0;
    fork
      send_frame(8'h65, 1'b1, 4, 0);
      begin
        while (!seen && lat < 2000) begin
          @(posedge clk_i);
          #1;
          lat++;
          if (valid_o) seen = 1'b1;
        end
      end
    join
    check("valid_latency", seen ? lat : 32'd9999, 763);
    check("head_65", {24'h0, data_o}, 32'h65);
    check("count_1", {28'h0, count_o}, 1);
    ready_i = 1'b1;
    wait_clks(1);
    ready_i = 1'b0;
    check("count_after_pop", {28'h0, count_o}, 0);
    check("pop_data_65", got_q.size() == 1 ? {24'h0, got_q[0]} : 32'hFFFF_FFFF, 32'h65);

    // Table of single frames, consumer always ready
    divisor_i = 16'd1;
    ready_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      got_q.delete();
      base_f = n_ferr;
      send_frame(vecs[v].dat, vecs[v].stop, 1, 0);
      wait_clks(40);
      check($sformatf("vec%0d_pushes", v), got_q.size(), vecs[v].exp_push);
      if (vecs[v].exp_push != 0) check_q($sformatf("vec%0d_data", v), 0, vecs[v].dat);
      check($sformatf("vec%0d_ferr", v), n_ferr - base_f, vecs[v].exp_ferr);
    end
    ready_i = 1'b0;

    // Back-to-back 0x00 then 0xFF
    divisor_i = 16'd4;
    got_q.delete();
    base_f = n_ferr;
    send_frame(8'h00, 1'b1, 4, 0);
    send_frame(8'hFF, 1'b1, 4, 0);
    wait_clks(10);
    check("b2b_count", {28'h0, count_o}, 2);
    check("b2b_ferr", n_ferr - base_f, 0);
    drain();
    check_q("b2b_first", 0, 8'h00);
    check_q("b2b_second", 1, 8'hFF);

    // Short low glitch: 3 ticks
    base_f = n_ferr;
    rx_i = 1'b0;
    wait_clks(15);
    rx_i = 1'b1;
    wait_clks(200);
    check("glitch_count", {28'h0, count_o}, 0);
    check("glitch_ferr", n_ferr - base_f, 0);
    got_q.delete();
    send_frame(8'hC3, 1'b1, 4, 0);
    wait_clks(10);
    check("post_glitch_head", {24'h0, data_o}, 32'hC3);
    drain();

    // Stop bit low followed by a 40 bit-time break
    base_f = n_ferr;
    send_frame(8'hA5, 1'b0, 4, 40);
    wait_clks(200);
    check("break_ferr_once", n_ferr - base_f, 1);
    check("break_count", {28'h0, count_o}, 0);

    // Overrun on the 9th byte
    base_o = n_ovr;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 4, 0);
    wait_clks(10);
    check("ovr_count_full", {28'h0, count_o}, 8);
    check("ovr_pulses", n_ovr - base_o, 1);
    got_q.delete();
    drain();
    check("ovr_drained", got_q.size(), 8);
    for (int i = 0; i < 8; i++) check_q($sformatf("ovr_data%0d", i), i, 8'(i + 1));

    // Full FIFO with a pop exactly at the stop sample
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, 4, 0);
    wait_clks(5);
    check("refill_count", {28'h0, count_o}, 8);
    got_q.delete();
    base_o = n_ovr;
    fork
      send_frame(8'h5A, 1'b1, 4, 0);
      begin
        wait_clks(762);
        ready_i = 1'b1;
        wait_clks(1);
        ready_i = 1'b0;
      end
    join
    wait_clks(5);
    check("simul_no_ovr", n_ovr - base_o, 0);
    check("simul_count", {28'h0, count_o}, 8);
    check_q("simul_popped", 0, 8'h11);
    check("simul_head", {24'h0, data_o}, 32'h12);

    // Reset in the middle of a frame
    rx_i = 1'b0;
    wait_clks(300);
    rst_i = 1'b1;
    wait_clks(2);
    check("mid_rst_valid", {31'h0, valid_o}, 0);
    check("mid_rst_count", {28'h0, count_o}, 0);
    check("mid_rst_data", {24'h0, data_o}, 0);
    check("mid_rst_ferr", {31'h0, frame_err_o}, 0);
    check("mid_rst_ovr", {31'h0, overrun_o}, 0);
    rx_i = 1'b1;
    wait_clks(1);
    rst_i = 1'b0;
    wait_clks(20);
    base_f = n_ferr;
    send_frame(8'h3C, 1'b1, 4, 0);
    wait_clks(10);
    check("post_rst_count", {28'h0, count_o}, 1);
    check("post_rst_data", {24'h0, data_o}, 32'h3C);
    check("post_rst_ferr", n_ferr - base_f, 0);
    drain();

    // Randomized frames, divisors, gaps and consumer readiness
    got_q.delete();
    exp_q.delete();
    base_f = n_ferr;
    base_o = n_ovr;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          ready_i = 1'($urandom_range(0, 1));
          wait_clks(1);
        end
      end
      begin
        for (int k = 0; k < 20; k++) begin
          div_r = $urandom_range(0, 3);
          divisor_i = 16'(div_r);
          nb = $urandom_range(0, 255);
          exp_q.push_back(8'(nb));
          send_frame(8'(nb), 1'b1, div_r, 0);
          wait_clks($urandom_range(0, 40));
        end
        wait_clks(10);
        rnd_on = 1'b0;
      end
    join
    wait_clks(2);
    drain();
    check("rnd_size", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) check_q($sformatf("rnd_data%0d", k), k, exp_q[k]);
    check("rnd_ferr", n_ferr - base_f, 0);
    check("rnd_ovr", n_ovr - base_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
